// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared definitions for the UART receive path (and the
// future transmitter). It provides the line FSM state type, the data word
// width and the default bit-period calculation.
package uart_rx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CLK_HZ = 40_000_000;
  localparam int unsigned BAUD   = 9600;

  // Clock cycles per serial bit for a given system clock and baud rate.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bus-side reader interface of the UART receiver.
//   rd_en, clear_err          : reader -> receiver (pop request, clear overrun)
//   rd_data, empty, full,
//   count                     : FIFO status and first-word-fall-through head byte
//   rx_done, frame_err        : 1-cycle event pulses
//   overrun                   : sticky dropped-byte flag
// master = bus reader, slave = uart_rx_fifo.
interface uart_rx_fifo_if #(
  parameter int unsigned ADDR_W = 3
) ();
  import uart_rx_fifo_pkg::*;

  logic              rd_en;
  logic              clear_err;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              rx_done;
  logic              frame_err;
  logic              overrun;

  modport master (
    output rd_en, clear_err,
    input  rd_data, empty, full, count, rx_done, frame_err, overrun
  );

  modport slave (
    input  rd_en, clear_err,
    output rd_data, empty, full, count, rx_done, frame_err, overrun
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with first-word fall-through read.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write request for push_data
//   rd_en       : pop request, ignored while empty
//   rd_data     : mem[rd_ptr], valid while !empty
//   empty, full : registered alongside count
//   count       : entries held, 0..DEPTH
//   push_ok     : push accepted this cycle
//   push_drop   : push rejected this cycle (full with no simultaneous pop)
module uart_sync_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [ADDR_W:0]  count,
  output logic             push_ok,
  output logic             push_drop
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_d;
  logic              do_pop;

  // A pop frees a slot in the same cycle, so a push at full still succeeds.
  assign push_ok   = push && (!full || rd_en);
  assign push_drop = push && full && !rd_en;
  assign do_pop    = rd_en && !empty;
  assign rd_data   = mem[rd_ptr];

  always_comb begin
    count_d = count;
    case ({push_ok, do_pop})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
      empty <= (count_d == '0);
      full  <= (count_d == FULL_CNT);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (LSB first, idle high) feeding an RX FIFO.
//   clk, rst_n : system clock, asynchronous active-low reset
//   rx         : serial input, asynchronous to clk
//   bus        : reader interface (slave side) - rd_en/rd_data/empty/full/
//                count, rx_done and frame_err pulses, sticky overrun with
//                synchronous clear_err
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned ADDR_W       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned        BCNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [BCNT_W-1:0] BIT_HALF = BCNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(CLKS_PER_BIT - 1);

  logic              rx_meta, rx_s;
  uart_state_t       state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              push_d, push_req;
  logic              fe_d;
  logic              push_ok, push_drop;
  logic              rx_done_q, frame_err_q, overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      push_req    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      push_req    <= push_d;
      frame_err_q <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    push_d  = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Half a bit in: confirm the start bit is still low, otherwise it was a glitch.
        if (bcnt_q == BIT_HALF) begin
          bcnt_d  = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bcnt_q == BIT_LAST) begin
          bcnt_d  = '0;
          shreg_d = {rx_s, shreg_q[DATA_W-1:1]};
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (bcnt_q == BIT_LAST) begin
          bcnt_d  = '0;
          state_d = IDLE;
          if (rx_s) push_d = 1'b1;
          else      fe_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // shreg_q is stable through IDLE/START, so the registered push can use it directly.
  uart_sync_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (shreg_q),
    .rd_en     (bus.rd_en),
    .rd_data   (bus.rd_data),
    .empty     (bus.empty),
    .full      (bus.full),
    .count     (bus.count),
    .push_ok   (push_ok),
    .push_drop (push_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_done_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_done_q <= push_ok;
      if (push_drop)          overrun_q <= 1'b1;
      else if (bus.clear_err) overrun_q <= 1'b0;
    end
  end

  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives uart_rx_fifo from a serial line model and checks
// the reader interface against a byte-queue reference model.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;

  uart_rx_fifo_if #(.ADDR_W(2)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_W       (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  int         exp_done = 0;
  int         exp_fe = 0;

  // Observed pulse activity (cycles high), sampled on the inactive edge
  int done_cnt = 0;
  int fe_cnt = 0;

  int vectors = 0;
  int miscompares = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_done === 1'b1) done_cnt++;
      if (bus.frame_err === 1'b1) fe_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "/count"}, 32'(bus.count), 32'(q.size()));
    chk({tag, "/empty"}, 32'(bus.empty), 32'(q.size() == 0));
    chk({tag, "/full"}, 32'(bus.full), 32'(q.size() == DEPTH));
    chk({tag, "/overrun"}, 32'(bus.overrun), 32'(m_ovr));
    chk({tag, "/rx_done"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "/frame_err"}, 32'(fe_cnt), 32'(exp_fe));
    if (q.size() != 0) chk({tag, "/head"}, 32'(bus.rd_data), 32'(q[0]));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "/empty"}, 32'(bus.empty), 32'd1);
    chk({tag, "/full"}, 32'(bus.full), 32'd0);
    chk({tag, "/count"}, 32'(bus.count), 32'd0);
    chk({tag, "/rd_data"}, 32'(bus.rd_data), 32'd0);
    chk({tag, "/rx_done"}, 32'(bus.rx_done), 32'd0);
    chk({tag, "/frame_err"}, 32'(bus.frame_err), 32'd0);
    chk({tag, "/overrun"}, 32'(bus.overrun), 32'd0);
  endtask

  // Send one 8N1 frame. rd_at >= 0 pulses rd_en for the cycle in which that
  // line-clock index ends (the byte's FIFO write lands 156 edges after the
  // start-bit edge: 2 sync + 1 detect + 1.5+8 bit periods + 1 write).
  // abort_at >= 0 returns mid-frame without updating the model.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int rd_at, input int abort_at);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int n = 0; n < 10 * CPB; n++) begin
      @(negedge clk);
      if (abort_at >= 0 && n == abort_at) return;
      rx = frame[n / CPB];
      bus.rd_en = (n == rd_at);
    end
    @(negedge clk);
    rx = 1'b1;
    bus.rd_en = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    if (rd_at >= 0 && q.size() != 0) void'(q.pop_front());
    if (stop_bit) begin
      if (q.size() < DEPTH) begin
        q.push_back(b);
        exp_done++;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      exp_fe++;
    end
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    chk({tag, "/pop_data"}, 32'(bus.rd_data), 32'(q[0]));
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    void'(q.pop_front());
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    rst_n = 1'b0;
    rx = 1'b1;
    bus.rd_en = 1'b0;
    bus.clear_err = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: two bytes, first-word fall-through, pop order
    send_frame(8'hA5, 1'b1, -1, -1);
    send_frame(8'h3C, 1'b1, -1, -1);
    check_state("t1_two");
    pop_check("t1_a5");
    check_state("t1_one");
    pop_check("t1_3c");
    check_state("t1_empty");

    // 2: short low glitch on idle line is rejected
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_state("t2_glitch");

    // 3: framing error then a clean byte
    send_frame(8'h55, 1'b0, -1, -1);
    check_state("t3_ferr");
    send_frame(8'h0F, 1'b1, -1, -1);
    check_state("t3_0f");
    pop_check("t3_pop");

    // 4: overflow to overrun, drain, clear_err
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, -1, -1);
      check_state("t4_fill");
    end
    for (int i = 0; i < DEPTH; i++) pop_check("t4_drain");
    check_state("t4_drained");
    @(negedge clk);
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    m_ovr = 1'b0;
    check_state("t4_clear");

    // 5: push into a full FIFO with a simultaneous pop
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    send_frame(8'h33, 1'b1, -1, -1);
    send_frame(8'h44, 1'b1, -1, -1);
    check_state("t5_full");
    send_frame(8'h77, 1'b1, 155, -1);
    check_state("t5_pushpop");
    for (int i = 0; i < DEPTH; i++) pop_check("t5_drain");
    check_state("t5_empty");

    // Random bytes, random framing errors, random reads (pointer wrap)
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, -1, -1);
      check_state("rand");
      if (q.size() != 0 && $urandom_range(0, 2) == 0) pop_check("rand_pop");
    end
    while (q.size() != 0) pop_check("rand_drain");
    @(negedge clk);
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    m_ovr = 1'b0;
    check_state("rand_end");

    // 6: async reset in DATA bit 4 with bytes held and overrun set
    for (int i = 0; i < DEPTH + 1; i++) send_frame(8'hE0 + 8'(i), 1'b1, -1, -1);
    check_state("t6_pre");
    send_frame(8'hC3, 1'b1, -1, 5 * CPB + 8);
    rx = 1'b1;
    rst_n = 1'b0;
    #1 reset_checks("t6_reset");
    q.delete();
    m_ovr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hC3, 1'b1, -1, -1);
    check_state("t6_c3");
    pop_check("t6_pop");
    check_state("t6_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
